// File: rtl/nibble_feeder_if.sv
// Word-side valid/ready channel feeding nibble_feeder.
// The master drives a word plus its frame-end marker; the slave answers with ready.
interface nibble_feeder_if #(
  parameter int NIBBLES = 8
);
  logic [4*NIBBLES-1:0] din;
  logic                 din_valid;
  logic                 din_last;
  logic                 din_ready;

  modport master (output din, din_valid, din_last, input din_ready);
  modport slave  (input din, din_valid, din_last, output din_ready);
endinterface

// File: rtl/nibble_feeder.sv
// Serializes 32-bit words into LSB-first nibbles for the downstream delay line.
// After a frame's last word it pushes DEPTH zero nibbles and pulses flush_done.
module nibble_feeder #(
  parameter int NIBBLES = 8,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  nibble_feeder_if.slave   up,
  input  logic             pause,
  output logic [3:0]       si,
  output logic             shn,
  output logic             busy,
  output logic             flush_done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_r;
  logic [W-1:0]  wreg_r;
  logic [CW-1:0] cnt_r;
  logic [FW-1:0] fcnt_r;
  logic          lastq_r;
  logic          flush_done_r;

  logic          ready_s;
  logic          shn_s;
  logic [3:0]    si_s;
  logic          accept_s;
  logic          last_nib_s;
  logic          last_flush_s;

  assign last_nib_s   = (cnt_r == CW'(NIBBLES - 1));
  assign last_flush_s = (fcnt_r == FW'(DEPTH - 1));
  assign accept_s     = up.din_valid & ready_s;

  // Output decode from registered state and pause; ready never depends on din_valid.
  always_comb begin
    ready_s = 1'b0;
    shn_s   = 1'b0;
    si_s    = 4'd0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
      end
      ST_SHIFT: begin
        if (!pause) begin
          shn_s   = 1'b1;
          si_s    = wreg_r[3:0];
          ready_s = last_nib_s & ~lastq_r;
        end else begin
          shn_s   = 1'b0;
          si_s    = 4'd0;
          ready_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (!pause) begin
          shn_s = 1'b1;
        end else begin
          shn_s = 1'b0;
        end
      end
      default: begin
        ready_s = 1'b0;
        shn_s   = 1'b0;
        si_s    = 4'd0;
      end
    endcase
  end

  // Word capture, nibble/flush sequencing and the flush_done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      wreg_r       <= {W{1'b0}};
      cnt_r        <= {CW{1'b0}};
      fcnt_r       <= {FW{1'b0}};
      lastq_r      <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      flush_done_r <= 1'b0;
      if (accept_s) begin
        // An accept in SHIFT only happens on the final nibble, giving seamless reload.
        wreg_r  <= up.din;
        lastq_r <= up.din_last;
        cnt_r   <= {CW{1'b0}};
        state_r <= ST_SHIFT;
      end else begin
        case (state_r)
          ST_SHIFT: begin
            if (!pause) begin
              wreg_r <= {4'd0, wreg_r[W-1:4]};
              if (last_nib_s) begin
                cnt_r   <= {CW{1'b0}};
                fcnt_r  <= {FW{1'b0}};
                state_r <= lastq_r ? ST_FLUSH : ST_IDLE;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else begin
              state_r <= state_r;
            end
          end
          ST_FLUSH: begin
            if (!pause) begin
              if (last_flush_s) begin
                fcnt_r       <= {FW{1'b0}};
                lastq_r      <= 1'b0;
                flush_done_r <= 1'b1;
                state_r      <= ST_IDLE;
              end else begin
                fcnt_r <= fcnt_r + FW'(1);
              end
            end else begin
              state_r <= state_r;
            end
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign up.din_ready = ready_s;
  assign shn          = shn_s;
  assign si           = si_s;
  assign busy         = (state_r != ST_IDLE);
  assign flush_done   = flush_done_r;

endmodule

// File: tb/tb_nibble_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-of-pending-nibbles reference model.
module tb_nibble_feeder;
  localparam int NIBBLES = 8;
  localparam int DEPTH   = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] si;
  logic       shn;
  logic       busy;
  logic       flush_done;

  int n_cmp = 0;
  int n_err = 0;
  int dut_shn_cnt = 0;
  int dut_done_cnt = 0;

  // Reference model: nibbles still owed downstream (flush zeros included).
  logic [3:0] pend[$];
  bit         tail_flush = 1'b0;
  bit         done_r     = 1'b0;

  nibble_feeder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_feeder #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (bus),
    .pause      (pause),
    .si         (si),
    .shn        (shn),
    .busy       (busy),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    tail_flush = 1'b0;
    done_r     = 1'b0;
  endtask

  // One clock: drive at negedge, check settled outputs, advance model at posedge.
  task automatic cycle(input logic v, input logic l, input logic [31:0] d,
                       input logic p, output bit acc);
    logic       e_ready;
    logic       e_shn;
    logic [3:0] e_si;
    @(negedge clk);
    bus.din_valid = v;
    bus.din_last  = l;
    bus.din       = d;
    pause         = p;
    #1;
    if (pend.size() == 0) begin
      e_ready = 1'b1; e_shn = 1'b0; e_si = 4'd0;
    end else if (p) begin
      e_ready = 1'b0; e_shn = 1'b0; e_si = 4'd0;
    end else begin
      e_shn   = 1'b1;
      e_si    = pend[0];
      e_ready = (pend.size() == 1) && !tail_flush;
    end
    chk("shn",        32'(shn),           32'(e_shn));
    chk("si",         32'(si),            32'(e_si));
    chk("busy",       32'(busy),          32'(pend.size() != 0));
    chk("din_ready",  32'(bus.din_ready), 32'(e_ready));
    chk("flush_done", 32'(flush_done),    32'(done_r));
    if (shn) dut_shn_cnt++;
    if (flush_done) dut_done_cnt++;
    acc = v && e_ready;
    @(posedge clk);
    done_r = 1'b0;
    if (e_shn) begin
      void'(pend.pop_front());
      if (pend.size() == 0 && tail_flush) begin
        done_r     = 1'b1;
        tail_flush = 1'b0;
      end
    end
    if (acc) begin
      for (int i = 0; i < NIBBLES; i++) pend.push_back(d[4*i +: 4]);
      if (l) begin
        for (int i = 0; i < DEPTH; i++) pend.push_back(4'd0);
        tail_flush = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, a);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) cycle(1'b1, l, d, 1'b0, got);
    chk("send_accepted", 32'(got), 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_shn"},   32'(shn),           32'd0);
    chk({tag, "_si"},    32'(si),            32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_ready"}, 32'(bus.din_ready), 32'd1);
    chk({tag, "_done"},  32'(flush_done),    32'd0);
  endtask

  initial begin
    bit a;
    int s0, d0;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    bus.din       = 32'd0;
    model_reset();

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      reset_checks("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // Single non-last word, no flush afterwards.
    s0 = dut_shn_cnt; d0 = dut_done_cnt;
    send(32'h87654321, 1'b0);
    idle(12);
    chk("single_shn_total", 32'(dut_shn_cnt - s0), 32'd8);
    chk("single_no_done",   32'(dut_done_cnt - d0), 32'd0);

    // Back-to-back words, second one last, then flush.
    s0 = dut_shn_cnt; d0 = dut_done_cnt;
    send(32'h87654321, 1'b0);
    send(32'hFEDCBA09, 1'b1);
    idle(20);
    chk("b2b_shn_total", 32'(dut_shn_cnt - s0), 32'd24);
    chk("b2b_done_once", 32'(dut_done_cnt - d0), 32'd1);

    // Pause for 3 cycles after the 3rd nibble.
    s0 = dut_shn_cnt;
    send(32'h87654321, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, a);
    idle(8);
    chk("pause_shn_total", 32'(dut_shn_cnt - s0), 32'd8);

    // Reset during the 4th flush cycle.
    d0 = dut_done_cnt;
    send(32'h13572468, 1'b1);
    idle(NIBBLES + 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_checks("midflush_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(12);
    chk("midflush_no_done", 32'(dut_done_cnt - d0), 32'd0);
    send(32'hA5A5A5A5, 1'b0);
    idle(10);

    // Word offered during a flush waits for the first IDLE cycle.
    send(32'h11111111, 1'b1);
    send(32'h2468ACE0, 1'b0);
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
            $urandom(), ($urandom_range(0, 7) == 0), a);
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nibble_feeder.md
# nibble_feeder

Upstream feeder for the 8-stage, 4-bit shift-enabled delay line. Accepts 32-bit words over a valid/ready handshake and serializes each into eight 4-bit nibbles, least-significant first, on `si` with a one-cycle-per-nibble `shn` strobe. After a word marked last, it drains the downstream delay line by pushing DEPTH zero nibbles, then pulses `flush_done`.

## Interface
- NIBBLES, 8: nibbles per input word; word width is 4*NIBBLES.
- DEPTH, 8: downstream shifter depth; sets the number of zero nibbles pushed during flush.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting it (low) forces the reset state immediately.
- din  input  4*NIBBLES  input word; `din[3:0]` is emitted first.
- din_valid  input  1  `din` / `din_last` valid.
- din_last  input  1  word is the final word of a frame; flush follows it.
- din_ready  output  1  feeder accepts a word this cycle when `din_valid` is also high.
- pause  input  1  stall: freezes shifting and flushing.
- si  output  4  nibble to the downstream shifter; 0 whenever `shn` = 0.
- shn  output  1  shift strobe to the downstream shifter.
- busy  output  1  high in SHIFT or FLUSH.
- flush_done  output  1  one-cycle pulse on completion of a flush.

## Operation
- States:
  - IDLE: no activity.
  - SHIFT: emitting the nibbles of a held word.
  - FLUSH: pushing zero nibbles.
- Internal state:
  - word register `wreg`.
  - nibble counter `cnt` (0..NIBBLES-1).
  - flush counter `fcnt` (0..DEPTH-1).
  - captured-last flag `lastq`.
- Handshake:
  - An accept occurs on the clock edge where `din_valid` and `din_ready` are both high.
  - `din_ready` is high in IDLE.
  - `din_ready` is high in SHIFT only when `cnt` = NIBBLES-1, `lastq` = 0 and `pause` = 0.
  - `din_ready` is low in FLUSH.
- On accept: `wreg` <= `din`, `lastq` <= `din_last`, `cnt` <= 0, state <= SHIFT.
- SHIFT with `pause` = 0:
  - `shn` = 1 and `si` = `wreg[3:0]`.
  - Each edge: `wreg` shifts right by 4 and `cnt` increments.
- Exit from SHIFT on the edge where `cnt` = NIBBLES-1:
  - If an accept occurs, reload and stay in SHIFT (back-to-back, no bubble).
  - Else if `lastq` = 1, go to FLUSH with `fcnt` = 0.
  - Else go to IDLE.
- FLUSH with `pause` = 0:
  - `shn` = 1 and `si` = 0; `fcnt` increments each edge.
  - On the edge where `fcnt` = DEPTH-1, go to IDLE and register `flush_done` = 1 for exactly the next cycle.
- `pause` = 1 in SHIFT or FLUSH:
  - `shn` = 0, `si` = 0, `din_ready` = 0.
  - All counters and `wreg` hold.
  - Resumes exactly where it stopped.
- `pause` has no effect in IDLE; accepts still occur.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - state IDLE, `wreg` = 0, `cnt` = 0, `fcnt` = 0, `lastq` = 0.
  - Outputs: `si` = 0, `shn` = 0, `busy` = 0, `flush_done` = 0, `din_ready` = 1.
- Latency: first `shn` is the cycle after the accept edge. A word occupies exactly NIBBLES `shn` cycles when not paused.
- Back-to-back words produce a continuous `shn` with no idle cycle.
- A flush follows the last nibble of a last-word immediately: DEPTH `shn` cycles, then `flush_done` in the first IDLE cycle.
- Reset asserted mid-word or mid-flush:
  - Outputs go to their reset values immediately.
  - No `flush_done` is emitted and the partial word is discarded.
- `shn`, `si`, `din_ready` and `busy` are decoded from registered state plus `pause`. They carry no combinational path from `din_valid`.

## Test plan
- Reset low for 2 cycles, then release; hold `din_valid` = 0 -> `shn` = 0, `si` = 0, `busy` = 0, `din_ready` = 1 throughout.
- Accept `din` = 0x87654321 with `din_last` = 0 -> `si` = 1,2,3,4,5,6,7,8 on the 8 cycles after accept, `shn` = 1 on each; then IDLE with `flush_done` never pulsing.
- Accept 0x87654321, then 0xFEDCBA09 accepted at `cnt` = 7 with `din_last` = 1 -> 16 contiguous `shn` cycles (`si` = 1..8, 9,0,A..F), then 8 cycles of `si` = 0 with `shn` = 1, then a single-cycle `flush_done`. Downstream shifter `so` shows 1..8 then 9,0,A..F during that stream.
- `pause` = 1 for 3 cycles after the 3rd nibble of 0x87654321 -> `shn` = 0 for those 3 cycles, then `si` resumes at 4. Total `shn` count stays 8.
- `rst` pulled low during the 4th flush cycle -> immediate `shn` = 0, `busy` = 0, `din_ready` = 1. No `flush_done` afterwards; the next accepted word starts at its nibble 0.
- `din_valid` = 1 during FLUSH -> `din_ready` = 0 and no accept. The word is accepted on the first IDLE cycle after `flush_done`.
